alu_instr_sequencer: RTL

Hardwired fetch/execute control unit for the mini-SRC datapath. It replaces hand-timed bench control of the datapath's `*in`/`*out` strobes. Each clock cycle it generates every datapath control signal for:
- instruction fetch;
- register-register and register-unary ALU instructions;
- the two-result MUL/DIV instructions.

Register count and memory wait depth are parameters. It sits between the datapath (bus, register file, ALU, IR, MAR/MDR) and the memory interface.

---
 rtl/mini_src_pkg.sv | 70 +++++++
 rtl/reg_field_decode.sv | 28 ++
 rtl/alu_instr_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mini_src_pkg.sv
// Shared definitions for the mini-SRC control unit.
//   - opcode encodings of the instructions the sequencer executes
//   - FSM state encoding
//   - bit positions of the IR fields
//   - opcode class helpers used by the execute-state decode
package mini_src_pkg;

    // Opcodes. Values 00001, 00010, 01011..01110, 10001 and 10100..11110
    // are not executed by this unit and fault in E3.
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10010;
    localparam logic [4:0] OP_NOT  = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // IR field bit positions (register fields are 4 bits wide, LSB given).
    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_F0    = 4'd1,
        S_F1    = 4'd2,
        S_F2    = 4'd3,
        S_E3    = 4'd4,
        S_E4    = 4'd5,
        S_E5    = 4'd6,
        S_E6    = 4'd7,
        S_HALT  = 4'd8,
        S_FAULT = 4'd9
    } state_e;

    // Single-result register-register ALU operations.
    function automatic logic is_alu3(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Two-result operations that write LO then HI.
    function automatic logic is_muldiv(input logic [4:0] op);
        case (op)
            OP_MUL, OP_DIV: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Unary operations: no Rc operand.
    function automatic logic is_unary(input logic [4:0] op);
        case (op)
            OP_NEG, OP_NOT: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_field_decode.sv
// Register-field decoder: turns an IR register index into a one-hot
// select and flags indices that name a register that does not exist.
// Ports:
//   idx_i    [RSEL_W-1:0]   register index from the IR
//   onehot_o [NUM_REGS-1:0] one-hot select (all zero when out of range)
//   oor_o                   index >= NUM_REGS
module reg_field_decode #(
    parameter int NUM_REGS = 16,
    parameter int RSEL_W   = 4
) (
    input  logic [RSEL_W-1:0]   idx_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                oor_o
);

    // One extra bit so the limit itself is representable when NUM_REGS == 2^RSEL_W.
    localparam logic [RSEL_W:0] LIMIT = (RSEL_W + 1)'(NUM_REGS);

    // Index compare per register; an out-of-range index matches nothing.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = (idx_i == RSEL_W'(i));
        end
    end

    assign oor_o = ({1'b0, idx_i} >= LIMIT);

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute control unit for the mini-SRC datapath.
// A Moore FSM (IDLE, F0..F2 fetch, E3..E6 execute, HALT, FAULT) whose
// strobes decode from the state register; in execute states the IR
// register fields select which register is driven or loaded.
// Ports:
//   Clock, Reset_n       clock (rising edge), async active-low reset
//   Run                  allow fetch of the next instruction
//   IR [31:0]            datapath instruction register
//   MemDone              memory read data valid this cycle
//   PCout..LOin          datapath strobes
//   Rin/Rout             one-hot register load / bus drive
//   ALUControl [4:0]     ALU operation (opcode) in E4
//   Busy/Halted/Fault    status
module alu_instr_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int RSEL_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Run,
    input  logic [31:0]         IR,
    input  logic                MemDone,
    output logic                PCout,
    output logic                MARin,
    output logic                PCin,
    output logic                IncrementPC,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [4:0]          ALUControl,
    output logic                Busy,
    output logic                Halted,
    output logic                Fault
);
    import mini_src_pkg::*;

    // Last F1 wait count tolerated; one more empty cycle faults.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e              state_q;
    logic [7:0]          wait_q;

    logic [4:0]          opcode_s;
    logic [RSEL_W-1:0]   ra_idx_s;
    logic [RSEL_W-1:0]   rb_idx_s;
    logic [RSEL_W-1:0]   rc_idx_s;
    logic [NUM_REGS-1:0] ra_oh_s;
    logic [NUM_REGS-1:0] rb_oh_s;
    logic [NUM_REGS-1:0] rc_oh_s;
    logic                ra_oor_s;
    logic                rb_oor_s;
    logic                rc_oor_s;
    logic                alu3_s;
    logic                muldiv_s;
    logic                unary_s;
    logic                uses_rc_s;
    logic                exec_ok_s;
    state_e              ret_state_s;
    logic                unused_ir_s;

    assign opcode_s = IR[IR_OPC_MSB:IR_OPC_LSB];
    assign ra_idx_s = IR[IR_RA_LSB +: RSEL_W];
    assign rb_idx_s = IR[IR_RB_LSB +: RSEL_W];
    assign rc_idx_s = IR[IR_RC_LSB +: RSEL_W];
    assign unused_ir_s = ^IR[IR_RC_LSB-1:0];

    reg_field_decode #(.NUM_REGS(NUM_REGS), .RSEL_W(RSEL_W)) u_dec_ra (
        .idx_i(ra_idx_s), .onehot_o(ra_oh_s), .oor_o(ra_oor_s)
    );
    reg_field_decode #(.NUM_REGS(NUM_REGS), .RSEL_W(RSEL_W)) u_dec_rb (
        .idx_i(rb_idx_s), .onehot_o(rb_oh_s), .oor_o(rb_oor_s)
    );
    reg_field_decode #(.NUM_REGS(NUM_REGS), .RSEL_W(RSEL_W)) u_dec_rc (
        .idx_i(rc_idx_s), .onehot_o(rc_oh_s), .oor_o(rc_oor_s)
    );

    assign alu3_s    = is_alu3(opcode_s);
    assign muldiv_s  = is_muldiv(opcode_s);
    assign unary_s   = is_unary(opcode_s);
    assign uses_rc_s = alu3_s | muldiv_s;

    // Executable only if the opcode is listed and every field it uses names
    // an existing register; NOP and HALT are handled before this matters.
    assign exec_ok_s = (alu3_s | muldiv_s | unary_s) & ~ra_oor_s & ~rb_oor_s
                       & ~(uses_rc_s & rc_oor_s);

    // Run is only looked at here, i.e. at IDLE and at instruction end.
    assign ret_state_s = Run ? S_F0 : S_IDLE;

    // State register and F1 wait counter.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Run) state_q <= S_F0;
                end
                S_F0: begin
                    state_q <= S_F1;
                    wait_q  <= 8'd0;
                end
                S_F1: begin
                    // MemDone wins over the timeout in the same cycle.
                    if (MemDone) begin
                        state_q <= S_F2;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_FAULT;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_F2: state_q <= S_E3;
                S_E3: begin
                    if (opcode_s == OP_NOP) begin
                        state_q <= ret_state_s;
                    end else if (opcode_s == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if (!exec_ok_s) begin
                        state_q <= S_FAULT;
                    end else begin
                        state_q <= S_E4;
                    end
                end
                S_E4: state_q <= S_E5;
                S_E5: state_q <= muldiv_s ? S_E6 : ret_state_s;
                S_E6: state_q <= ret_state_s;
                S_HALT:  state_q <= S_HALT;
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_FAULT;
            endcase
        end
    end

    // Strobe decode from the state register (plus IR fields in execute).
    always_comb begin
        PCout       = 1'b0;
        MARin       = 1'b0;
        PCin        = 1'b0;
        IncrementPC = 1'b0;
        Read        = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        ZLOout      = 1'b0;
        ZHIout      = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        Rin         = {NUM_REGS{1'b0}};
        Rout        = {NUM_REGS{1'b0}};
        ALUControl  = 5'd0;
        Busy        = 1'b0;
        Halted      = 1'b0;
        Fault       = 1'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_F0: begin
                Busy        = 1'b1;
                PCout       = 1'b1;
                MARin       = 1'b1;
                IncrementPC = 1'b1;
                Zin         = 1'b1;
            end
            S_F1: begin
                Busy   = 1'b1;
                ZLOout = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
                // Counter is still zero only in the first F1 cycle.
                PCin   = (wait_q == 8'd0);
            end
            S_F2: begin
                Busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_E3: begin
                Busy = 1'b1;
                if (exec_ok_s) begin
                    Rout = rb_oh_s;
                    Yin  = 1'b1;
                end else begin
                    Rout = {NUM_REGS{1'b0}};
                    Yin  = 1'b0;
                end
            end
            S_E4: begin
                Busy       = 1'b1;
                ALUControl = opcode_s;
                Zin        = 1'b1;
                if (uses_rc_s) begin
                    Rout = rc_oh_s;
                end else begin
                    Rout = {NUM_REGS{1'b0}};
                end
            end
            S_E5: begin
                Busy   = 1'b1;
                ZLOout = 1'b1;
                if (muldiv_s) begin
                    LOin = 1'b1;
                end else begin
                    Rin = ra_oh_s;
                end
            end
            S_E6: begin
                Busy   = 1'b1;
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            S_FAULT: Fault  = 1'b1;
            default: Fault  = 1'b1;
        endcase
    end

endmodule
